fir_output_serializer: RTL and testbench
========================================

Name: fir_output_serializer

Overview:
- Parallel-to-serial back end for the L=3 reduced-complexity parallel FIR.
- Accepts one block of L output samples per handshake from the parallel filter core, buffers blocks in a small FIFO, and emits the samples one per beat in time order on a valid/ready stream.
- Restores the original sample-rate ordering (y(Lk), y(Lk+1), ..., y(Lk+L-1)) for downstream consumers.

Parameters:
- DATA_WIDTH, 64, width of one filter output sample (signed).
- L, 3, parallelism factor (samples per block). Legal range is 2 or more.
- DEPTH, 4, FIFO depth in blocks. Must be a power of two and at least 2.

Ports:
- clk  input  1  single clock.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  block valid from the parallel FIR.
- in_ready  output  1  FIFO can accept a block.
- in_data  input  L*DATA_WIDTH  block of samples; lane i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]; lane 0 is the earliest sample.
- out_valid  output  1  serial sample valid.
- out_ready  input  1  downstream accepts the sample.
- out_data  output  DATA_WIDTH  signed serial sample.
- out_last  output  1  high on lane L-1 of each block.
- level  output  $clog2(DEPTH+1)  number of occupied blocks.
- overflow  output  1  sticky flag, set when in_valid is high while in_ready is low.

Behaviour:
- Reset (asynchronous, active-high): wr_ptr, rd_ptr, count, lane all go to 0; overflow is cleared. Consequently out_valid=0, in_ready=1, level=0, out_last=0. Storage contents are don't-care.
- Reset asserted mid-operation discards all buffered blocks and any partially emitted block. After reset the first output is lane 0 of the next accepted block.
- Push: occurs when in_valid && in_ready. The block is written at wr_ptr, and wr_ptr advances modulo DEPTH.
- in_ready = (count < DEPTH). It is a pure function of registered state and has no combinational path from out_ready.
- Output signals are combinational from registered state:
  - out_valid = (count != 0).
  - out_data = lane `lane` of the block at rd_ptr.
  - out_last = out_valid && (lane == L-1).
- Beat: occurs when out_valid && out_ready.
  - If lane < L-1, lane increments.
  - If lane == L-1, lane returns to 0, rd_ptr advances modulo DEPTH, and the block is popped.
- Latency: a block pushed at edge N makes its lane 0 visible at out_data during the cycle after edge N. Minimum latency is 1 cycle.
- Count update:
  - count += 1 on push without pop.
  - count -= 1 on pop without push.
  - count is unchanged when a push and a pop occur on the same edge.
- Full with a simultaneous pop: no push occurs because in_ready=0. The freed slot becomes visible on the next cycle.
- Empty with a simultaneous push: no pop is possible. out_valid rises on the next cycle.
- Pointer wrap: DEPTH-1 wraps to 0. Pointers are $clog2(DEPTH) bits, and occupancy is held in a separate count register.
- Backpressure: while out_valid && !out_ready, out_data, out_last and lane are held stable.
- overflow: set on any cycle with in_valid && !in_ready. The block offered in that cycle is dropped, not queued. The flag is cleared only by reset.
- level equals count.
- Sustained throughput: one sample per cycle at the output. With out_ready held at 1, the FIFO accepts at most one block every L cycles at steady state.

Decomposition:
- Shared package fir_pkg contains:
  - localparam L_PAR = 3 and DATA_OUT_W = 64;
  - typedef logic signed [DATA_OUT_W-1:0] sample_t;
  - typedef sample_t block_t [L_PAR].
- Sub-module fir_block_fifo (DEPTH x L*DATA_WIDTH storage, wr_ptr/rd_ptr/count, push/pop, full/empty).
- The top level adds the lane counter, the output mux and the overflow flag.

Test Plan:
- Reset, then push block {lane0=1, lane1=2, lane2=3} with out_ready=1. Expect out_data 1, 2, 3 on consecutive cycles starting 1 cycle after the push; out_last high only on 3; out_valid low afterwards.
- Hold out_ready=0 and push 4 blocks. Expect in_ready=0 and level=4. A 5th in_valid sets overflow=1 and that block is never output. Then release out_ready: 12 samples in push order, with level draining 4→0.
- Full FIFO with out_ready=1 and in_valid=1 held. Expect the push to be accepted only the cycle after a pop (at a lane 2 beat), count not exceeding 4, and no samples lost or duplicated over 20 blocks.
- Toggle out_ready pseudo-randomly with signed values (-1, 0x7FFF_FFFF_FFFF_FFFF, 0x8000_0000_0000_0000). Expect out_data stable while stalled, sign bits preserved, and order intact.
- Assert reset after lane 1 of a block with 2 blocks queued. Expect out_valid=0, level=0, overflow=0 immediately, and the next pushed block to emit from lane 0.
- Run more than 2*DEPTH blocks back to back with out_ready=1. Expect correct ordering across pointer wrap and output beats with no bubbles.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared types and defaults for the L=3 parallel FIR output path.
package fir_pkg;
  localparam int L_PAR      = 3;
  localparam int DATA_OUT_W = 64;

  typedef logic signed [DATA_OUT_W-1:0] sample_t;
  typedef sample_t block_t [L_PAR];
endpackage

// File: rtl/fir_block_fifo.sv
// Block-wide FIFO: DEPTH entries of WIDTH bits, pointers wrap naturally (DEPTH is a power of two).
module fir_block_fifo #(
  parameter int WIDTH = 192,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wr_data,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  // NOTE: storage has no reset; only pointers/count define validity, and an un-reset array maps to plain RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rd_data = mem[rd_ptr];
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
endmodule

// File: rtl/fir_output_serializer.sv
// Parallel-to-serial back end: buffers L-sample blocks and emits them one sample per beat, lane 0 first.
module fir_output_serializer
  import fir_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_OUT_W,
  parameter int L          = L_PAR,
  parameter int DEPTH      = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [L*DATA_WIDTH-1:0]      in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DATA_WIDTH-1:0] out_data,
  output logic                         out_last,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         overflow
);
  localparam int LW = $clog2(L);
  localparam logic [LW-1:0] LAST_LANE = LW'(L-1);

  logic [L*DATA_WIDTH-1:0] rd_block;
  logic                    full;
  logic                    empty;
  logic                    push;
  logic                    pop;
  logic                    beat;
  logic                    lane_last;
  logic [LW-1:0]           lane;

  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  assign beat      = out_valid && out_ready;
  assign lane_last = (lane == LAST_LANE);
  assign pop       = beat && lane_last;
  assign out_last  = out_valid && lane_last;

  fir_block_fifo #(
    .WIDTH (L*DATA_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .pop     (pop),
    .wr_data (in_data),
    .rd_data (rd_block),
    .full    (full),
    .empty   (empty),
    .count   (level)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lane     <= '0;
      overflow <= 1'b0;
    end else begin
      if (beat) lane <= lane_last ? '0 : lane + 1'b1;
      // Offered block is dropped when full; the flag stays set until reset.
      if (in_valid && !in_ready) overflow <= 1'b1;
    end
  end

  // NOTE: defaulting out_data before the loop keeps this block free of inferred latches.
  always_comb begin
    out_data = '0;
    for (int i = 0; i < L; i++) begin
      if (lane == LW'(i)) out_data = rd_block[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end
endmodule

// File: tb/tb_fir_output_serializer.sv
// Self-checking bench: directed phases with random data, checked against a sample-queue reference model.
module tb_fir_output_serializer;
  import fir_pkg::*;

  localparam int DEPTH = 4;
  localparam int LVW   = $clog2(DEPTH+1);

  logic                          clk = 1'b0;
  logic                          reset;
  logic                          in_valid;
  logic                          in_ready;
  logic [L_PAR*DATA_OUT_W-1:0]   in_data;
  logic                          out_valid;
  logic                          out_ready;
  logic signed [DATA_OUT_W-1:0]  out_data;
  logic                          out_last;
  logic [LVW-1:0]                level;
  logic                          overflow;

  fir_output_serializer #(
    .DATA_WIDTH (DATA_OUT_W),
    .L          (L_PAR),
    .DEPTH      (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .level     (level),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  // Reference model: pending samples in output order; blocks are whole until their samples leave.
  sample_t q[$];
  bit      exp_ovf;
  block_t  cur_blk;
  int      n_cmp;
  int      n_err;
  int      n_push;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("check %s mismatched", tag);
    end
  endtask

  function automatic int exp_level();
    return (q.size() + L_PAR - 1) / L_PAR;
  endfunction

  function automatic sample_t rnd_sample();
    case ($urandom_range(0, 4))
      0:       return -64'sd1;
      1:       return 64'h7FFF_FFFF_FFFF_FFFF;
      2:       return 64'h8000_0000_0000_0000;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic drive_block(input block_t b);
    cur_blk = b;
    for (int i = 0; i < L_PAR; i++) in_data[i*DATA_OUT_W +: DATA_OUT_W] = b[i];
  endtask

  task automatic drive_random();
    block_t b;
    for (int i = 0; i < L_PAR; i++) b[i] = rnd_sample();
    drive_block(b);
  endtask

  // Check outputs for the current cycle, then advance one clock and update the model.
  task automatic cycle();
    bit push;
    bit beat;
    int lvl;
    lvl = exp_level();
    chk("out_valid", out_valid, q.size() != 0);
    chk("in_ready", in_ready, lvl < DEPTH);
    chk("level", level, lvl);
    chk("overflow", overflow, exp_ovf);
    if (q.size() != 0) begin
      chk("out_data", out_data, q[0]);
      chk("out_last", out_last, (q.size() % L_PAR) == 1);
    end else begin
      chk("out_last_idle", out_last, 0);
    end
    push = in_valid && (lvl < DEPTH);
    beat = (q.size() != 0) && out_ready;
    if (in_valid && lvl >= DEPTH) exp_ovf = 1'b1;
    @(posedge clk);
    if (beat) void'(q.pop_front());
    if (push) for (int i = 0; i < L_PAR; i++) q.push_back(cur_blk[i]);
    n_push += int'(push);
    #1;
  endtask

  task automatic drain(input int n);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (n) cycle();
  endtask

  initial begin
    block_t b;
    n_cmp = 0; n_err = 0; n_push = 0; exp_ovf = 1'b0;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_level", level, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_overflow", overflow, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Single block 1,2,3 with the sink always ready.
    out_ready = 1'b1;
    b[0] = 64'sd1; b[1] = 64'sd2; b[2] = 64'sd3;
    drive_block(b);
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    repeat (5) cycle();

    // Fill to DEPTH while stalled, then one more offer that must be dropped.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    repeat (DEPTH) begin drive_random(); cycle(); end
    b[0] = 64'sh0BAD; b[1] = 64'sh0BAD; b[2] = 64'sh0BAD;
    drive_block(b);
    cycle();
    chk("overflow_set", overflow, 1);
    drain(3*DEPTH + 3);

    // Full FIFO, sink ready, source always offering: 20 accepted blocks.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    repeat (DEPTH) begin drive_random(); cycle(); end
    out_ready = 1'b1;
    n_push = 0;
    for (int c = 0; c < 200 && n_push < 20; c++) begin
      drive_random();
      cycle();
    end
    chk("full_20_blocks", n_push >= 20, 1);
    drain(3*DEPTH + 3);

    // Random stalls and offers with extreme signed values.
    repeat (300) begin
      in_valid  = ($urandom_range(0, 1) == 1);
      out_ready = ($urandom_range(0, 2) != 0);
      drive_random();
      cycle();
    end
    drain(3*DEPTH + 3);

    // Reset mid-block with two blocks queued, after lanes 0 and 1 have left.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    repeat (2) begin drive_random(); cycle(); end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (2) cycle();
    out_ready = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_level", level, 0);
    chk("midrst_overflow", overflow, 0);
    chk("midrst_in_ready", in_ready, 1);
    q.delete();
    exp_ovf = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    b[0] = 64'sh11; b[1] = 64'sh22; b[2] = 64'sh33;
    drive_block(b);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    cycle();
    chk("post_rst_lane0", out_data, 64'h11);
    drain(5);

    // Back-to-back traffic across several pointer wraps.
    in_valid  = 1'b1;
    out_ready = 1'b1;
    n_push = 0;
    repeat (40) begin drive_random(); cycle(); end
    chk("wrap_blocks", n_push > 2*DEPTH, 1);
    drain(3*DEPTH + 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
